// File: rtl/cpu_defs.sv
// Shared definitions for the stack CPU operand stack.
// Holds the stack entry width, the pop-count encodings and the error bit indices.
package cpu_defs;

  localparam int ST_W = 35;

  typedef enum logic [1:0] {
    ST_POP_NONE = 2'd0,
    ST_POP_ONE  = 2'd1,
    ST_POP_TWO  = 2'd2,
    ST_POP_ILL  = 2'd3
  } st_pop_e;

  localparam int ST_ERR_OVF = 0;
  localparam int ST_ERR_UNF = 1;

endpackage

// File: rtl/cpu_stack_regfile.sv
// Spill array for the operand stack: holds every entry below NOS.
// One synchronous write port and two combinational read ports: rd0 reads
// rd_a_i, rd1 reads rd_a_i-1 so a pop of two can refill both top registers.
// Addresses past the last slot read as zero.
module cpu_stack_regfile
  import cpu_defs::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [ST_W-1:0] wd_i,
  input  logic [AW-1:0]   rd_a_i,
  output logic [ST_W-1:0] rd0_o,
  output logic [ST_W-1:0] rd1_o
);

  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 3);

  logic [ST_W-1:0] mem_q [0:DEPTH-3];
  logic [AW-1:0]   rd1_a;

  // Write the spilled NOS entry on the clock edge; contents are not reset.
  always_ff @(posedge clk) begin
    if (we_i && (wa_i <= LAST_A)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Combinational reads of the top spill slot and the one below it.
  always_comb begin
    rd1_a = rd_a_i - AW'(1);
    rd0_o = '0;
    rd1_o = '0;
    if (rd_a_i <= LAST_A) rd0_o = mem_q[rd_a_i];
    if (rd1_a  <= LAST_A) rd1_o = mem_q[rd1_a];
  end

endmodule

// File: rtl/cpu_stack.sv
// Operand stack unit for the stack CPU pipeline.
// TOS and NOS live in registers; deeper entries spill into cpu_stack_regfile.
// Stage 2 pops (unless stalled), then the stage 5 push is applied, each edge.
// Optional macro CPU_STACK_ERR_EN adds the sticky st__err output
// (bit 0 overflow, bit 1 underflow/illegal pop) and error messages.
module cpu_stack
  import cpu_defs::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            stall_2a,
  input  logic [1:0]      st__pop_2a,
  input  logic            st__push_5a,
  input  logic [ST_W-1:0] st__to_push_5a,
  output logic [ST_W-1:0] st__top_0_2a,
  output logic [ST_W-1:0] st__top_n_2a,
  output logic [AW:0]     st__count,
  output logic            st__empty,
  output logic            st__full
`ifdef CPU_STACK_ERR_EN
  ,
  output logic [1:0]      st__err
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  logic [AW:0]     count_q, count_d;
  logic [ST_W-1:0] tos_q, tos_d;
  logic [ST_W-1:0] nos_q, nos_d;

  logic [1:0]      pe;
  logic [AW:0]     pe_w;
  logic [AW:0]     c1;
  logic            illegal;
  logic            under;
  logic            ovf;
  logic            push_eff;
  logic [ST_W-1:0] tos_p, nos_p;

  logic            we;
  logic [AW-1:0]   wa;
  logic [AW-1:0]   rd_a;
  logic [ST_W-1:0] rd0, rd1;

  cpu_stack_regfile #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_regfile (
    .clk   (clk),
    .we_i  (we),
    .wa_i  (wa),
    .wd_i  (nos_q),
    .rd_a_i(rd_a),
    .rd0_o (rd0),
    .rd1_o (rd1)
  );

  // Work out the pop phase, then the push phase, giving next TOS/NOS/count.
  always_comb begin
    illegal  = !stall_2a && (st__pop_2a == ST_POP_ILL);
    pe       = stall_2a ? ST_POP_NONE : (illegal ? ST_POP_TWO : st__pop_2a);
    pe_w     = {{(AW-1){1'b0}}, pe};
    under    = pe_w > count_q;
    c1       = under ? '0 : (count_q - pe_w);
    ovf      = st__push_5a && (pe == ST_POP_NONE) && (count_q == DEPTH_C);
    push_eff = st__push_5a && !ovf;
    rd_a     = count_q[AW-1:0] - AW'(3);
    wa       = count_q[AW-1:0] - AW'(2);
    we       = push_eff && (pe == ST_POP_NONE) && (count_q >= TWO_C);

    tos_p = tos_q;
    nos_p = nos_q;
    case (pe)
      ST_POP_ONE: begin
        tos_p = (c1 != '0)    ? nos_q : '0;
        nos_p = (c1 >= TWO_C) ? rd0   : '0;
      end
      ST_POP_TWO: begin
        tos_p = (c1 != '0)    ? rd0 : '0;
        nos_p = (c1 >= TWO_C) ? rd1 : '0;
      end
      default: begin
        tos_p = tos_q;
        nos_p = nos_q;
      end
    endcase

    if (push_eff) begin
      tos_d = st__to_push_5a;
      nos_d = tos_p;
    end else begin
      tos_d = tos_p;
      nos_d = nos_p;
    end
    count_d = c1 + {{AW{1'b0}}, push_eff};
  end

  // Register the stack top and count; reset empties the stack at once.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
    end
  end

  assign st__top_0_2a = tos_q;
  assign st__top_n_2a = nos_q;
  assign st__count    = count_q;
  assign st__empty    = (count_q == '0);
  assign st__full     = (count_q == DEPTH_C);

`ifdef CPU_STACK_ERR_EN
  logic [1:0] err_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_q <= '0;
    end else begin
      if (ovf)             err_q[ST_ERR_OVF] <= 1'b1;
      if (under || illegal) err_q[ST_ERR_UNF] <= 1'b1;
    end
  end

  // Report each error event as it happens.
  always @(posedge clk) begin
    if (rst_b && ovf) $display("cpu_stack: overflow, push dropped at count %0d", count_q);
    if (rst_b && (under || illegal)) $display("cpu_stack: underflow or illegal pop %0d at count %0d", st__pop_2a, count_q);
  end

  assign st__err = err_q;
`endif

endmodule
